alu_fault_monitor: RTL and testbench

- Downstream consumer of the dual-ALU lockstep compare stage. Takes the per-operation XOR syndrome (8-bit data difference plus carry difference) and classifies mismatches over time.
- A single-cycle upset is a transient. THRESH consecutive mismatches is a persistent fault, which raises a sticky flag and an interrupt pulse.
- Keeps a saturating error count and captures the first failing syndrome for software.

---
 rtl/alu_mon_pkg.sv | 21 ++
 rtl/alu_fault_monitor_if.sv | 32 +++
 rtl/alu_fault_monitor_sat_counter.sv | 30 +++
 rtl/alu_fault_monitor.sv | 127 ++++++++++++
 tb/tb_alu_fault_monitor.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/alu_mon_pkg.sv
// Shared types and widths for the ALU lockstep fault monitor.
//   mon_state_e : classifier FSM state (OK / SUSPECT / FAULT)
//   syn_t       : captured syndrome {carry, data}
package alu_mon_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SYN_W    = 9;
  localparam int unsigned CONSEC_W = 4;

  typedef enum logic [1:0] {
    MON_OK      = 2'd0,
    MON_SUSPECT = 2'd1,
    MON_FAULT   = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic              carry;
    logic [DATA_W-1:0] data;
  } syn_t;

endpackage

// File: rtl/alu_fault_monitor_if.sv
// Bus between the lockstep compare stage / software and the fault monitor.
//   master : drives valid_in, x, y, clear; observes the monitor outputs
//   slave  : the monitor itself
interface alu_fault_monitor_if
  import alu_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic              valid_in;
  logic [DATA_W-1:0] x;
  logic              y;
  logic              clear;
  logic              mismatch;
  logic              fault;
  logic              fault_irq;
  logic [CNT_W-1:0]  err_count;
  logic [SYN_W-1:0]  syn;
  logic              syn_valid;
  logic [1:0]        state;

  modport master (
    output valid_in, x, y, clear,
    input  mismatch, fault, fault_irq, err_count, syn, syn_valid, state
  );

  modport slave (
    input  valid_in, x, y, clear,
    output mismatch, fault, fault_irq, err_count, syn, syn_valid, state
  );

endinterface

// File: rtl/alu_fault_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear wins over inc.
//   clk, rst_n : clock, async active-low reset
//   inc        : count up by one this cycle
//   clr        : return to zero
//   count      : registered count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/alu_fault_monitor.sv
// Classifies lockstep ALU mismatches as transient or persistent, keeps a
// saturating error count and captures the first failing syndrome.
//   clk, rst_n : clock, async active-low reset
//   mon        : slave side of alu_fault_monitor_if (samples in, status out)
module alu_fault_monitor
  import alu_mon_pkg::*;
#(
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_fault_monitor_if.slave  mon
);

  localparam logic [CONSEC_W-1:0] THRESH_C = CONSEC_W'(THRESH);

  mon_state_e          r_state;
  mon_state_e          w_next_state;
  logic [CONSEC_W-1:0] r_consec;
  logic [CONSEC_W-1:0] w_next_consec;
  logic                w_next_fault;
  logic                r_fault;
  logic                r_irq;
  logic                r_mismatch;
  syn_t                r_syn;
  logic                r_syn_valid;
  logic                w_mm;
  logic                w_sample;
  logic                w_hit;
  logic [CNT_W-1:0]    w_err_count;

  // A clear discards any same-cycle sample entirely.
  assign w_mm     = (mon.x != '0) | mon.y;
  assign w_sample = mon.valid_in & ~mon.clear;
  assign w_hit    = w_sample & w_mm;

  // FSM state and consecutive-mismatch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MON_OK;
      r_consec <= '0;
    end else begin
      r_state  <= w_next_state;
      r_consec <= w_next_consec;
    end
  end

  // Next-state: only valid samples advance; FAULT is absorbing until clear
  always_comb begin
    w_next_state  = r_state;
    w_next_consec = r_consec;
    if (mon.clear) begin
      w_next_state  = MON_OK;
      w_next_consec = '0;
    end else begin
      unique case (r_state)
        MON_OK: begin
          if (w_hit) begin
            w_next_consec = CONSEC_W'(1);
            w_next_state  = (THRESH_C == CONSEC_W'(1)) ? MON_FAULT : MON_SUSPECT;
          end
        end
        MON_SUSPECT: begin
          if (w_sample) begin
            if (w_mm) begin
              w_next_consec = r_consec + CONSEC_W'(1);
              if ((r_consec + CONSEC_W'(1)) == THRESH_C) begin
                w_next_state = MON_FAULT;
              end
            end else begin
              w_next_state  = MON_OK;
              w_next_consec = '0;
            end
          end
        end
        MON_FAULT: begin
        end
        default: begin
          w_next_state  = MON_OK;
          w_next_consec = '0;
        end
      endcase
    end
  end

  assign w_next_fault = (w_next_state == MON_FAULT);

  // Registered status flags and first-syndrome capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault     <= 1'b0;
      r_irq       <= 1'b0;
      r_mismatch  <= 1'b0;
      r_syn       <= '0;
      r_syn_valid <= 1'b0;
    end else begin
      r_fault    <= w_next_fault;
      r_irq      <= w_next_fault & ~r_fault;
      r_mismatch <= w_hit;
      if (mon.clear) begin
        r_syn       <= '0;
        r_syn_valid <= 1'b0;
      end else if (w_hit && !r_syn_valid) begin
        r_syn       <= '{carry: mon.y, data: mon.x};
        r_syn_valid <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hit),
    .clr   (mon.clear),
    .count (w_err_count)
  );

  assign mon.mismatch  = r_mismatch;
  assign mon.fault     = r_fault;
  assign mon.fault_irq = r_irq;
  assign mon.err_count = w_err_count;
  assign mon.syn       = r_syn;
  assign mon.syn_valid = r_syn_valid;
  assign mon.state     = 2'(r_state);

endmodule

// File: tb/tb_alu_fault_monitor.sv
// Directed bench for alu_fault_monitor: one THRESH=3/CNT_W=16 instance for
// classification, clear and reset behaviour; one CNT_W=4 instance for
// counter saturation.
module tb_alu_fault_monitor;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_irq    = 0;

  always #5 clk = ~clk;

  alu_fault_monitor_if #(.CNT_W(16)) ifa ();
  alu_fault_monitor_if #(.CNT_W(4))  ifb ();

  alu_fault_monitor #(.THRESH(3), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (ifa)
  );

  alu_fault_monitor #(.THRESH(3), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (ifb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus to instance A; returns 1 ns after the edge.
  task automatic drive_a(input logic v, input logic [7:0] xv, input logic yv, input logic clr);
    ifa.valid_in = v;
    ifa.x        = xv;
    ifa.y        = yv;
    ifa.clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] xv, input logic yv);
    ifb.valid_in = v;
    ifb.x        = xv;
    ifb.y        = yv;
    ifb.clear    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [1:0] st, input logic [15:0] cnt,
                         input logic mm, input logic flt, input logic irq,
                         input logic [8:0] sy, input logic sv);
    check_eq({tag, ".state"},     32'(ifa.state),     32'(st));
    check_eq({tag, ".err_count"}, 32'(ifa.err_count), 32'(cnt));
    check_eq({tag, ".mismatch"},  32'(ifa.mismatch),  32'(mm));
    check_eq({tag, ".fault"},     32'(ifa.fault),     32'(flt));
    check_eq({tag, ".fault_irq"}, 32'(ifa.fault_irq), 32'(irq));
    check_eq({tag, ".syn"},       32'(ifa.syn),       32'(sy));
    check_eq({tag, ".syn_valid"}, 32'(ifa.syn_valid), 32'(sv));
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.valid_in = 1'b0; ifa.x = '0; ifa.y = 1'b0; ifa.clear = 1'b0;
    ifb.valid_in = 1'b0; ifb.x = '0; ifb.y = 1'b0; ifb.clear = 1'b0;
    #12;
    check_a("reset", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
    check_eq("reset_b.err_count", 32'(ifb.err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean stream
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, 8'h00, 1'b0, 1'b0);
      check_eq("clean.mismatch", 32'(ifa.mismatch), 32'd0);
    end
    check_a("clean_end", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);

    // Transient, then a fresh suspect
    drive_a(1'b1, 8'h04, 1'b0, 1'b0);
    check_a("trans1", 2'd1, 16'd1, 1'b1, 1'b0, 1'b0, 9'h004, 1'b1);
    drive_a(1'b1, 8'h00, 1'b0, 1'b0);
    check_a("trans2", 2'd0, 16'd1, 1'b0, 1'b0, 1'b0, 9'h004, 1'b1);
    drive_a(1'b1, 8'h10, 1'b1, 1'b0);
    check_a("trans3", 2'd1, 16'd2, 1'b1, 1'b0, 1'b0, 9'h004, 1'b1);

    // Clear from SUSPECT wipes everything
    drive_a(1'b0, 8'h00, 1'b0, 1'b1);
    check_a("clr_susp", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);

    // Persistent fault across an invalid gap
    drive_a(1'b1, 8'h01, 1'b0, 1'b0);
    check_a("pers1", 2'd1, 16'd1, 1'b1, 1'b0, 1'b0, 9'h001, 1'b1);
    drive_a(1'b0, 8'hAA, 1'b1, 1'b0);
    check_a("gap1", 2'd1, 16'd1, 1'b0, 1'b0, 1'b0, 9'h001, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    check_a("gap2", 2'd1, 16'd1, 1'b0, 1'b0, 1'b0, 9'h001, 1'b1);
    drive_a(1'b1, 8'h80, 1'b0, 1'b0);
    check_a("pers2", 2'd1, 16'd2, 1'b1, 1'b0, 1'b0, 9'h001, 1'b1);
    drive_a(1'b1, 8'h00, 1'b1, 1'b0);
    check_a("pers3", 2'd2, 16'd3, 1'b1, 1'b1, 1'b1, 9'h001, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    check_a("fault_hold", 2'd2, 16'd3, 1'b0, 1'b1, 1'b0, 9'h001, 1'b1);
    drive_a(1'b1, 8'h00, 1'b0, 1'b0);
    check_a("fault_clean", 2'd2, 16'd3, 1'b0, 1'b1, 1'b0, 9'h001, 1'b1);
    drive_a(1'b1, 8'h20, 1'b0, 1'b0);
    check_a("fault_mm", 2'd2, 16'd4, 1'b1, 1'b1, 1'b0, 9'h001, 1'b1);

    // Clear beats a same-cycle valid mismatch
    drive_a(1'b1, 8'hFF, 1'b0, 1'b1);
    check_a("clr_prio", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    check_a("clr_after", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);

    // Clear in OK with no history
    drive_a(1'b0, 8'h00, 1'b0, 1'b1);
    check_a("clr_noop", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);

    // Async reset while in SUSPECT
    drive_a(1'b1, 8'h02, 1'b0, 1'b0);
    check_a("pre_rst", 2'd1, 16'd1, 1'b1, 1'b0, 1'b0, 9'h002, 1'b1);
    ifa.valid_in = 1'b0;
    ifa.x        = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
    @(posedge clk);
    #1;
    check_a("rst_held", 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_a(1'b1, 8'h08, 1'b0, 1'b0);
    check_a("post_rst1", 2'd1, 16'd1, 1'b1, 1'b0, 1'b0, 9'h008, 1'b1);
    drive_a(1'b1, 8'h00, 1'b1, 1'b0);
    check_a("post_rst2", 2'd1, 16'd2, 1'b1, 1'b0, 1'b0, 9'h008, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    check_a("post_rst3", 2'd1, 16'd2, 1'b0, 1'b0, 1'b0, 9'h008, 1'b1);

    // Saturation on the 4-bit counter instance
    for (int i = 1; i <= 20; i++) begin
      drive_b(1'b1, 8'h00, 1'b1);
      if (ifb.fault_irq === 1'b1) n_irq++;
      check_eq("sat.err_count", 32'(ifb.err_count), (i < 15) ? 32'(i) : 32'd15);
    end
    check_eq("sat.fault", 32'(ifb.fault), 32'd1);
    check_eq("sat.state", 32'(ifb.state), 32'd2);
    check_eq("sat.irq_pulses", 32'(n_irq), 32'd1);
    check_eq("sat.syn", 32'(ifb.syn), 32'h100);
    drive_b(1'b0, 8'h00, 1'b0);
    check_eq("sat.hold", 32'(ifb.err_count), 32'd15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
